// File: rtl/stack_pkg.sv
// Shared constants for the 8-Queen solver stack: entry width, depth and
// occupancy-counter width. Also used by the stack controller and the solver
// datapath.
package stack_pkg;
  localparam int DATA_W     = 4;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int COUNT_W    = DEPTH_LOG2 + 1;

  typedef logic [DATA_W-1:0]     entry_t;
  typedef logic [COUNT_W-1:0]    count_t;
  typedef logic [DEPTH_LOG2-1:0] addr_t;
endpackage

// File: rtl/stack_datapath_if.sv
// Bus between the stack controller (master) and the stack datapath (slave).
//   push/pop/din             : request side, driven by the controller
//   dout/dout_valid/top      : data returned to the controller/solver
//   count/msb/zero/proto_err : occupancy and status
interface stack_datapath_if;
  import stack_pkg::*;

  logic   push;
  logic   pop;
  entry_t din;
  entry_t dout;
  logic   dout_valid;
  entry_t top;
  count_t count;
  logic   msb;
  logic   zero;
  logic   proto_err;

  modport master (
    output push, pop, din,
    input  dout, dout_valid, top, count, msb, zero, proto_err
  );

  modport slave (
    input  push, pop, din,
    output dout, dout_valid, top, count, msb, zero, proto_err
  );
endinterface

// File: rtl/stack_regfile.sv
// DEPTH x DATA_W register array for the stack entries.
//   clk              : rising-edge clock
//   we/waddr/wdata   : synchronous write port
//   raddr_a/rdata_a  : asynchronous read (current top, count-1)
//   raddr_b/rdata_b  : asynchronous read (entry below top, count-2)
// Contents are intentionally not reset.
module stack_regfile
  import stack_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  addr_t  waddr,
  input  entry_t wdata,
  input  addr_t  raddr_a,
  output entry_t rdata_a,
  input  addr_t  raddr_b,
  output entry_t rdata_b
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_datapath.sv
// Pointer, status flags and output registers of the solver LIFO.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of stack_datapath_if (push/pop/din in;
//           dout/dout_valid/top/count/msb/zero/proto_err out)
module stack_datapath
  import stack_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  stack_datapath_if.slave  bus
);

  count_t count_q;
  entry_t dout_q;
  logic   dout_valid_q;
  entry_t top_q;
  logic   proto_err_q;

  logic   full;
  logic   empty;
  logic   push_ok;
  logic   pop_ok;
  logic   req_err;
  count_t count_m1;
  count_t count_m2;
  entry_t rd_top;
  entry_t rd_below;

  assign full  = count_q[DEPTH_LOG2];
  assign empty = (count_q == '0);

  assign push_ok = bus.push & ~bus.pop & ~full;
  assign pop_ok  = bus.pop & ~bus.push & ~empty;
  assign req_err = (bus.push & bus.pop)
                 | (bus.push & ~bus.pop & full)
                 | (bus.pop & ~bus.push & empty);

  assign count_m1 = count_q - count_t'(1);
  assign count_m2 = count_q - count_t'(2);

  // Write is gated by reset so a push coinciding with reset leaves no trace.
  stack_regfile u_regfile (
    .clk     (clk),
    .we      (push_ok & reset),
    .waddr   (count_q[DEPTH_LOG2-1:0]),
    .wdata   (bus.din),
    .raddr_a (count_m1[DEPTH_LOG2-1:0]),
    .rdata_a (rd_top),
    .raddr_b (count_m2[DEPTH_LOG2-1:0]),
    .rdata_b (rd_below)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      top_q        <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (req_err) proto_err_q <= 1'b1;
      if (push_ok) begin
        count_q <= count_q + count_t'(1);
        top_q   <= bus.din;
      end else if (pop_ok) begin
        count_q      <= count_m1;
        dout_q       <= rd_top;
        dout_valid_q <= 1'b1;
        // Popping the last entry leaves nothing to peek at.
        top_q        <= (count_q >= count_t'(2)) ? rd_below : '0;
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.msb        = full;
  assign bus.zero       = empty;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.top        = top_q;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_stack_datapath.sv
module tb_stack_datapath;
  import stack_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stack_datapath_if ifc ();

  stack_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue, back() is the top of the stack.
  logic [3:0] q [$];
  logic [3:0] m_dout;
  logic       m_dv;
  logic       m_err;

  function automatic logic [15:0] exp_vec();
    logic [3:0] cnt;
    logic [3:0] tp;
    cnt = 4'(q.size());
    tp  = (q.size() > 0) ? q[q.size()-1] : 4'd0;
    return {cnt, tp, q.size() == DEPTH, q.size() == 0, m_dv, m_dout, m_err};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {ifc.count, ifc.top, ifc.msb, ifc.zero, ifc.dout_valid, ifc.dout, ifc.proto_err};
  endfunction

  // Drives one cycle of stimulus and advances the model by the same cycle.
  task automatic apply(input logic p, input logic o, input logic [3:0] d, input logic r = 1'b1);
    ifc.push = p;
    ifc.pop  = o;
    ifc.din  = d;
    reset    = r;
    @(posedge clk);
    #1;
    m_dv = 1'b0;
    if (!r) begin
      q.delete();
      m_dout = 4'd0;
      m_err  = 1'b0;
    end else if (p && o) begin
      m_err = 1'b1;
    end else if (p) begin
      if (q.size() == DEPTH) m_err = 1'b1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) m_err = 1'b1;
      else begin
        m_dout = q.pop_back();
        m_dv   = 1'b1;
      end
    end
    ifc.push = 1'b0;
    ifc.pop  = 1'b0;
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 4'd0, 1'b0);
    apply(1'b0, 1'b0, 4'd0, 1'b0);
    apply(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 16'b0000_0000_0_1_0_0000_0) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", dut_vec(), 16'b0000_0000_0_1_0_0000_0);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      apply(1'b1, 1'b0, 4'(i));
      checks++;
      if (ifc.count !== 4'(i) || ifc.top !== 4'(i)) begin
        errors++;
        $display("FAIL fill[%0d] count %0d top %0d exp %0d", i, ifc.count, ifc.top, i);
      end
    end
    checks++;
    if (ifc.msb !== 1'b1 || ifc.zero !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL fill_flags got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    apply(1'b1, 1'b0, 4'hF);
    checks++;
    if (ifc.count !== 4'd8 || ifc.top !== 4'd8 || ifc.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow count %0d top %0d err %0b exp 8 8 1", ifc.count, ifc.top, ifc.proto_err);
    end
  endtask

  task automatic test_drain();
    for (int i = 8; i >= 1; i--) begin
      apply(1'b0, 1'b1, 4'd0);
      checks++;
      if (ifc.dout !== 4'(i) || ifc.dout_valid !== 1'b1 || ifc.count !== 4'(i-1)) begin
        errors++;
        $display("FAIL drain[%0d] dout %0d dv %0b count %0d", i, ifc.dout, ifc.dout_valid, ifc.count);
      end
    end
    apply(1'b0, 1'b0, 4'd0);
    checks++;
    if (ifc.dout_valid !== 1'b0 || ifc.zero !== 1'b1 || ifc.top !== 4'd0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL drain_end got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_underflow();
    do_reset();
    apply(1'b0, 1'b1, 4'd0);
    checks++;
    if (ifc.dout_valid !== 1'b0 || ifc.count !== 4'd0 || ifc.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL underflow dv %0b count %0d err %0b exp 0 0 1", ifc.dout_valid, ifc.count, ifc.proto_err);
    end
  endtask

  task automatic test_both();
    do_reset();
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 4'(i + 4));
    apply(1'b1, 1'b1, 4'd1);
    checks++;
    if (ifc.count !== 4'd3 || ifc.proto_err !== 1'b1 || ifc.top !== 4'd6 || ifc.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL push_pop count %0d err %0b top %0d exp 3 1 6", ifc.count, ifc.proto_err, ifc.top);
    end
  endtask

  task automatic test_interleave();
    logic [1:0] ops  [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
    logic [3:0] dins [6] = '{4'd5, 4'd9, 4'd0, 4'd2, 4'd0, 4'd0};
    logic [3:0] tops [6] = '{4'd5, 4'd9, 4'd5, 4'd2, 4'd5, 4'd0};
    logic [3:0] douts[6] = '{4'd0, 4'd0, 4'd9, 4'd0, 4'd2, 4'd5};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(ops[i] == 2'd1, ops[i] == 2'd2, dins[i]);
      checks++;
      if (ifc.top !== tops[i] || (ops[i] == 2'd2 && (ifc.dout !== douts[i] || ifc.dout_valid !== 1'b1))) begin
        errors++;
        $display("FAIL interleave[%0d] top %0d dout %0d exp top %0d dout %0d", i, ifc.top, ifc.dout, tops[i], douts[i]);
      end
    end
    checks++;
    if (ifc.zero !== 1'b1) begin
      errors++;
      $display("FAIL interleave_zero got %0b exp 1", ifc.zero);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 4'(i + 10));
    apply(1'b1, 1'b0, 4'd14, 1'b0);
    checks++;
    if (ifc.count !== 4'd0 || ifc.top !== 4'd0 || ifc.zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid count %0d top %0d exp 0 0", ifc.count, ifc.top);
    end
    apply(1'b1, 1'b0, 4'd7);
    apply(1'b0, 1'b1, 4'd0);
    checks++;
    if (ifc.dout !== 4'd7 || ifc.dout_valid !== 1'b1 || ifc.count !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_pop dout %0d dv %0b count %0d exp 7 1 0", ifc.dout, ifc.dout_valid, ifc.count);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (i % 100 == 99)
        apply(1'b0, 1'b0, 4'd0, 1'b0);
      else
        apply(r < 50, (r >= 45 && r < 95), 4'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    m_dout   = 4'd0;
    m_dv     = 1'b0;
    m_err    = 1'b0;
    ifc.push = 1'b0;
    ifc.pop  = 1'b0;
    ifc.din  = 4'd0;
    reset    = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_both();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_datapath.md
Name: stack_datapath

Overview:
Storage and pointer side of the LIFO used by the 8-Queen solver: holds the placed-queen entries and executes the one-cycle push/pop strobes issued by the stack control FSM. It returns the status pair msb (stack full) and zero (stack empty) that the controller uses to decide overflow and underflow. The block sits between the controller and the solver datapath, which supplies the push data and consumes the pop data.

Parameters:
DATA_W, 4, entry width (3-bit column index plus 1 valid/tag bit)
DEPTH_LOG2, 3, log2 of the entry count; DEPTH = 2**DEPTH_LOG2 = 8 rows

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-low reset
push  in  1  one-cycle push strobe from the controller
pop  in  1  one-cycle pop strobe from the controller
din  in  DATA_W  entry written on push
dout  out  DATA_W  entry returned by the last accepted pop (registered)
dout_valid  out  1  one-cycle pulse, 1 clk after an accepted pop
top  out  DATA_W  registered copy of the current top entry (peek); 0 when empty
count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
msb  out  1  count[DEPTH_LOG2]; 1 iff the stack is full
zero  out  1  1 iff count == 0
proto_err  out  1  sticky error flag; set by an illegal request

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low on port reset. All state updates on the rising clk edge.
- Reset (reset == 0 sampled at an edge) sets:
  - count = 0, zero = 1, msb = 0
  - dout = 0, dout_valid = 0, top = 0, proto_err = 0
  - Memory contents are not cleared; they are don't-care.
  - Reset overrides a push or pop in the same cycle.
- Pointer: count is an unsigned (DEPTH_LOG2+1)-bit counter. Write address = count[DEPTH_LOG2-1:0]; read address = count-1.
- Accepted push (push=1, pop=0, msb=0):
  - mem[count] <= din; count <= count+1.
  - top <= din in the same edge, so top is valid the next cycle.
- Accepted pop (pop=1, push=0, zero=0):
  - dout <= mem[count-1]; dout_valid <= 1 for exactly one cycle; count <= count-1.
  - top <= mem[count-2] when count >= 2, else top <= 0.
- Latency: flags, count and top reflect an accepted operation 1 cycle after the strobe. Pop data is 1 cycle after the strobe.
- Boundary conditions (the state-changing part is always a no-op):
  - Push while msb=1: count, mem and top unchanged; proto_err <= 1.
  - Pop while zero=1: count unchanged; dout holds its value; dout_valid stays 0; proto_err <= 1.
  - push=1 and pop=1 together: both ignored; proto_err <= 1.
- proto_err is cleared only by reset.
- msb and zero are decoded combinationally from the count register, so they are glitch-free relative to clk. Back-to-back strobes on consecutive cycles are legal.
- A push immediately after a pop returns to the same slot; there is no wrap-around, and count never exceeds DEPTH or underflows below 0.
- Reset asserted mid-sequence empties the stack. Entries written before reset are not visible on top or dout afterwards.

Decomposition:
- Shared package stack_pkg holds the common constants: DATA_W, DEPTH_LOG2, DEPTH, and COUNT_W = DEPTH_LOG2+1. The stack controller and the solver datapath use the same package.
- One natural sub-module is stack_regfile: a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port at address count-1 / count-2.
- The pointer, flags and output registers stay in stack_datapath.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> count=0, zero=1, msb=0, top=0, dout_valid=0, proto_err=0.
- Fill: push din=1..8 on 8 consecutive cycles -> count steps 1..8; top=8 after the last push; msb=1 and zero=0 one cycle after the 8th push.
- Drain LIFO order: from full, pop 8 consecutive cycles -> dout = 8,7,...,1, each with a one-cycle dout_valid 1 clk after its strobe; final count=0, zero=1, top=0.
- Illegal requests:
  - Push when count=8 -> count stays 8, top unchanged, proto_err=1.
  - After reset, pop when empty -> dout_valid=0, count=0, proto_err=1.
  - push=pop=1 with count=3 -> count stays 3, proto_err=1.
- Interleave: push 5, push 9, pop, push 2, pop, pop -> dout sequence 9, 2, 5; top sequence 5, 9, 5, 2, 5, 0; final zero=1.
- Reset mid-operation: push 3 entries, assert reset for 1 cycle together with a push -> count=0, top=0, the push is ignored; a following push 7 then pop returns dout=7.
